// File: rtl/fetch_entry_fifo_pkg.sv
// Shared fetch-side types for the fetch entry FIFO.
// Entry layout, FIFO state encoding and default sizing.
package fetch_entry_fifo_pkg;

  localparam int unsigned FETCH_VLEN = 64;
  localparam int unsigned FETCH_XLEN = 64;
  localparam int unsigned FIFO_DEPTH = 4;

  typedef struct packed {
    logic [FETCH_VLEN-1:0] addr;
    logic [31:0]           instr;
    logic                  bp_taken;
    logic                  ex_valid;
    logic [FETCH_XLEN-1:0] ex_cause;
    logic [FETCH_XLEN-1:0] ex_tval;
  } fetch_fifo_entry_t;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fifo_state_e;

endpackage

// File: rtl/fetch_entry_fifo_if.sv
// Valid/ready bundle carrying one fetch entry.
// Master drives valid/entry, slave drives ready.
interface fetch_entry_if;
  import fetch_entry_fifo_pkg::*;

  logic              valid;
  logic              ready;
  fetch_fifo_entry_t entry;

  modport master (output valid, output entry, input ready);
  modport slave  (input valid, input entry, output ready);
  modport monitor (input valid, input entry, input ready);

endinterface

// File: rtl/fetch_entry_fifo_ram.sv
// Fetch entry storage: one write port, async read port.
// Contents are not reset; validity is tracked by the FIFO count.
module fetch_fifo_ram
  import fetch_entry_fifo_pkg::*;
#(
  parameter int unsigned DEPTH = FIFO_DEPTH,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  fetch_fifo_entry_t wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output fetch_fifo_entry_t rdata_o
);

  fetch_fifo_entry_t mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fetch_entry_fifo.sv
// Fetch-to-decode decoupling FIFO; sinks fetches after a fault until flush.
// FETCH_ENTRY_FIFO_BYPASS_EN enables a zero-latency empty-FIFO bypass.
module fetch_entry_fifo
  import fetch_entry_fifo_pkg::*;
#(
  parameter int unsigned DEPTH = FIFO_DEPTH,
  parameter int unsigned VLEN  = FETCH_VLEN,
  parameter int unsigned XLEN  = FETCH_XLEN,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [VLEN-1:0] in_addr_i,
  input  logic [31:0]     in_instr_i,
  input  logic            in_bp_taken_i,
  input  logic            in_ex_valid_i,
  input  logic [XLEN-1:0] in_ex_cause_i,
  input  logic [XLEN-1:0] in_ex_tval_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [VLEN-1:0] out_addr_o,
  output logic [31:0]     out_instr_o,
  output logic            out_bp_taken_o,
  output logic            out_ex_valid_o,
  output logic [XLEN-1:0] out_ex_cause_o,
  output logic [XLEN-1:0] out_ex_tval_o,
  output logic [AW:0]     count_o
);

  if (VLEN != FETCH_VLEN || XLEN != FETCH_XLEN || DEPTH < 2 ||
      (1 << AW) != DEPTH) begin : g_bad_cfg
    $error("fetch_entry_fifo: unsupported DEPTH/VLEN/XLEN");
  end

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  fifo_state_e       state_q, state_d;
  logic [AW-1:0]     wptr_q, wptr_d;
  logic [AW-1:0]     rptr_q, rptr_d;
  logic [AW:0]       cnt_q, cnt_d;
  fetch_fifo_entry_t in_e, rd_e, head_e;
  logic              empty, accept, deq, byp, wr_en, rd_en;

  assign in_e = '{
    addr:     in_addr_i,
    instr:    in_instr_i,
    bp_taken: in_bp_taken_i,
    ex_valid: in_ex_valid_i,
    ex_cause: in_ex_cause_i,
    ex_tval:  in_ex_tval_i
  };

  assign empty      = (cnt_q == '0);
  assign in_ready_o = (state_q == HALT) | (cnt_q != FULL);
  assign accept     = in_valid_i & in_ready_o &
                      (state_q == RUN) & ~flush_i;

`ifdef FETCH_ENTRY_FIFO_BYPASS_EN
  assign byp = empty & (state_q == RUN) & ~flush_i & in_valid_i;
`else
  assign byp = 1'b0;
`endif

  assign out_valid_o = (~empty & ~flush_i) | byp;
  assign deq         = out_valid_o & out_ready_i;
  // A bypassed entry taken this cycle never touches storage
  assign wr_en       = accept & ~(byp & out_ready_i);
  assign rd_en       = deq & ~byp;

  assign head_e = byp   ? in_e :
                  empty ? '0   : rd_e;

  assign out_addr_o     = head_e.addr;
  assign out_instr_o    = head_e.instr;
  assign out_bp_taken_o = head_e.bp_taken;
  assign out_ex_valid_o = head_e.ex_valid;
  assign out_ex_cause_o = head_e.ex_cause;
  assign out_ex_tval_o  = head_e.ex_tval;
  assign count_o        = cnt_q;

  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    cnt_d   = cnt_q;
    unique case (1'b1)
      flush_i: begin
        state_d = RUN;
        wptr_d  = '0;
        rptr_d  = '0;
        cnt_d   = '0;
      end
      default: begin
        if (wr_en) wptr_d = wptr_q + 1'b1;
        if (rd_en) rptr_d = rptr_q + 1'b1;
        if (wr_en & ~rd_en) cnt_d = cnt_q + 1'b1;
        if (rd_en & ~wr_en) cnt_d = cnt_q - 1'b1;
        if (accept & in_ex_valid_i) state_d = HALT;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= RUN;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
    end
  end

  fetch_fifo_ram #(.DEPTH(DEPTH)) u_ram (
    .clk_i   (clk_i),
    .we_i    (wr_en),
    .waddr_i (wptr_q),
    .wdata_i (in_e),
    .raddr_i (rptr_q),
    .rdata_o (rd_e)
  );

  a_cnt_bound: assert property (
    @(posedge clk_i) disable iff (rst_i) cnt_q <= FULL);
  a_no_deq_empty: assert property (
    @(posedge clk_i) disable iff (rst_i) !(rd_en && empty));

endmodule

// File: tb/tb_fetch_entry_fifo.sv
// Scoreboard bench for fetch_entry_fifo: directed stimulus, queued
// expectations, negedge monitor popping on every output handshake.
module tb_fetch_entry_fifo;
  import fetch_entry_fifo_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  fetch_entry_if in_if ();
  fetch_entry_if out_if ();

  logic [63:0] o_addr;
  logic [31:0] o_instr;
  logic        o_bp;
  logic        o_exv;
  logic [63:0] o_cause;
  logic [63:0] o_tval;
  logic [2:0]  count;

  assign out_if.entry = '{
    addr: o_addr, instr: o_instr, bp_taken: o_bp,
    ex_valid: o_exv, ex_cause: o_cause, ex_tval: o_tval
  };

  fetch_entry_fifo dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .flush_i        (flush),
    .in_valid_i     (in_if.valid),
    .in_ready_o     (in_if.ready),
    .in_addr_i      (in_if.entry.addr),
    .in_instr_i     (in_if.entry.instr),
    .in_bp_taken_i  (in_if.entry.bp_taken),
    .in_ex_valid_i  (in_if.entry.ex_valid),
    .in_ex_cause_i  (in_if.entry.ex_cause),
    .in_ex_tval_i   (in_if.entry.ex_tval),
    .out_valid_o    (out_if.valid),
    .out_ready_i    (out_if.ready),
    .out_addr_o     (o_addr),
    .out_instr_o    (o_instr),
    .out_bp_taken_o (o_bp),
    .out_ex_valid_o (o_exv),
    .out_ex_cause_o (o_cause),
    .out_ex_tval_o  (o_tval),
    .count_o        (count)
  );

  fetch_fifo_entry_t exp_q[$];
  fetch_fifo_entry_t mon_e;
  fetch_fifo_entry_t e;
  int tests = 0;
  int fails = 0;

  function automatic fetch_fifo_entry_t mk(
    logic [63:0] a, logic ex, logic [63:0] c);
    fetch_fifo_entry_t r;
    r.addr     = a;
    r.instr    = a[31:0] ^ 32'h0000_0013;
    r.bp_taken = a[2];
    r.ex_valid = ex;
    r.ex_cause = ex ? c : 64'h0;
    r.ex_tval  = ex ? a : 64'h0;
    return r;
  endfunction

  task automatic chk(string n, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", n, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic v, fetch_fifo_entry_t d);
    in_if.valid = v;
    in_if.entry = d;
  endtask

  always @(negedge clk) begin
    if (!rst && out_if.valid && out_if.ready) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_out: got addr %0h want none", o_addr);
      end else begin
        mon_e = exp_q.pop_front();
        if (out_if.entry !== mon_e) begin
          fails++;
          $display("FAIL out_entry: got addr %0h ex %0b cause %0h want addr %0h ex %0b cause %0h",
                   o_addr, o_exv, o_cause,
                   mon_e.addr, mon_e.ex_valid, mon_e.ex_cause);
        end
      end
    end
  end

  initial begin
    in_if.valid  = 1'b0;
    in_if.entry  = '0;
    out_if.ready = 1'b0;
    #2;
    chk("rst_out_valid", 64'(out_if.valid), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_in_ready", 64'(in_if.ready), 64'd1);
    chk("rst_out_addr", o_addr, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // fill and drain
    for (int i = 0; i < 4; i++) begin
      e = mk(64'h8000_0000 + 64'(4 * i), 1'b0, 64'h0);
      drive(1'b1, e);
      exp_q.push_back(e);
      tick();
    end
    drive(1'b1, mk(64'h8000_0010, 1'b0, 64'h0));
    chk("full_in_ready", 64'(in_if.ready), 64'd0);
    chk("full_count", 64'(count), 64'd4);
    tick();
    chk("full_no_enq", 64'(count), 64'd4);
    drive(1'b0, '0);
    out_if.ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("drain_count", 64'(count), 64'(3 - k));
    end
    out_if.ready = 1'b0;

    // simultaneous push/pop at count 2, wrapping pointers
    for (int i = 0; i < 2; i++) begin
      e = mk(64'h1000 + 64'(4 * i), 1'b0, 64'h0);
      drive(1'b1, e);
      exp_q.push_back(e);
      tick();
    end
    chk("pp_start_count", 64'(count), 64'd2);
    out_if.ready = 1'b1;
    for (int i = 2; i < 12; i++) begin
      e = mk(64'h1000 + 64'(4 * i), 1'b0, 64'h0);
      drive(1'b1, e);
      exp_q.push_back(e);
      tick();
      chk("pp_count", 64'(count), 64'd2);
    end
    drive(1'b0, '0);
    tick();
    tick();
    chk("pp_end_count", 64'(count), 64'd0);
    out_if.ready = 1'b0;

    // fault halt
    e = mk(64'h100, 1'b0, 64'h0);
    drive(1'b1, e);
    exp_q.push_back(e);
    tick();
    e = mk(64'h104, 1'b1, 64'h1);
    drive(1'b1, e);
    exp_q.push_back(e);
    tick();
    drive(1'b1, mk(64'h108, 1'b0, 64'h0));
    chk("halt_in_ready", 64'(in_if.ready), 64'd1);
    tick();
    chk("halt_peak_count", 64'(count), 64'd2);
    drive(1'b0, '0);
    out_if.ready = 1'b1;
    tick();
    tick();
    chk("halt_drained", 64'(count), 64'd0);
    drive(1'b1, mk(64'h10C, 1'b0, 64'h0));
    #1;
    chk("halt_no_out", 64'(out_if.valid), 64'd0);
    tick();
    chk("halt_dropped", 64'(count), 64'd0);
    drive(1'b0, '0);
    out_if.ready = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;

    // flush while halted with entries stored
    drive(1'b1, mk(64'h400, 1'b0, 64'h0));
    tick();
    drive(1'b1, mk(64'h404, 1'b0, 64'h0));
    tick();
    drive(1'b1, mk(64'h408, 1'b1, 64'h2));
    tick();
    chk("fl_pre_count", 64'(count), 64'd3);
    flush = 1'b1;
    drive(1'b1, mk(64'h40C, 1'b0, 64'h0));
    out_if.ready = 1'b1;
    #1;
    chk("fl_out_gated", 64'(out_if.valid), 64'd0);
    tick();
    flush = 1'b0;
    drive(1'b0, '0);
    chk("fl_count", 64'(count), 64'd0);
    chk("fl_out_valid", 64'(out_if.valid), 64'd0);
    e = mk(64'h200, 1'b0, 64'h0);
    drive(1'b1, e);
    exp_q.push_back(e);
    chk("fl_in_ready", 64'(in_if.ready), 64'd1);
    tick();
    drive(1'b0, '0);
    tick();
    chk("fl_after_count", 64'(count), 64'd0);
    out_if.ready = 1'b0;

    // asynchronous reset mid-operation
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, mk(64'h500 + 64'(4 * i), 1'b0, 64'h0));
      tick();
    end
    drive(1'b0, '0);
    chk("ar_pre_count", 64'(count), 64'd3);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_out_valid", 64'(out_if.valid), 64'd0);
    chk("ar_count", 64'(count), 64'd0);
    chk("ar_in_ready", 64'(in_if.ready), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // empty-FIFO latency / bypass
    e = mk(64'h300, 1'b0, 64'h0);
    out_if.ready = 1'b1;
    drive(1'b1, e);
    exp_q.push_back(e);
    #1;
`ifdef FETCH_ENTRY_FIFO_BYPASS_EN
    chk("byp_out_valid", 64'(out_if.valid), 64'd1);
    chk("byp_out_addr", o_addr, 64'h300);
    tick();
    drive(1'b0, '0);
    chk("byp_count", 64'(count), 64'd0);
`else
    chk("lat_out_valid0", 64'(out_if.valid), 64'd0);
    tick();
    drive(1'b0, '0);
    chk("lat_out_valid1", 64'(out_if.valid), 64'd1);
    chk("lat_out_addr", o_addr, 64'h300);
    chk("lat_count", 64'(count), 64'd1);
    tick();
    chk("lat_count_end", 64'(count), 64'd0);
`endif
    out_if.ready = 1'b0;
    tick();
    chk("sb_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
